// File: rtl/mem_pkg.sv
// Shared constants and helpers for the mem FIFO slice.
package mem_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 16;

    // Ceiling log2, usable in constant expressions for pointer widths.
    function automatic int mem_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int PTR_W_DEFAULT = mem_clog2(DEPTH_DEFAULT);

endpackage

// File: rtl/mem_ram.sv
// Storage array for the FIFO: one synchronous write port, one
// combinational read port so the top can register the word on the read edge.
module mem_ram
    import mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = mem_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] store [DEPTH];

    // Write the addressed word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            store[waddr] <= wdata;
        end
    end

    assign rdata = store[raddr];

endmodule

// File: rtl/mem.sv
// Synchronous FIFO: pointers, occupancy count, flags and the registered
// Dataout. When empty, a simultaneous read and write bypasses storage.
module mem
    import mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd,
    input  logic             wr,
    input  logic [WIDTH-1:0] Datain,
    output logic [WIDTH-1:0] Dataout
);

    localparam int PTR_W = mem_clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] ram_rdata;

    logic empty;
    logic full;
    logic write_through;
    logic do_read;
    logic do_write;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Qualify requests: reading from empty while writing forwards Datain
    // directly, and a full FIFO still accepts a write when a read frees a slot.
    always_comb begin
        write_through = 1'b0;
        do_read       = 1'b0;
        do_write      = 1'b0;
        if (rd && wr && empty) begin
            write_through = 1'b1;
        end else begin
            do_read  = rd && !empty;
            do_write = wr && (!full || (rd && !empty));
        end
    end

    mem_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (do_write && !rst),
        .waddr (wr_ptr),
        .wdata (Datain),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_write && !do_read) begin
                count <= count + CNT_W'(1);
            end else if (do_read && !do_write) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Registered read data; holds unless a read or write-through is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            Dataout <= '0;
        end else if (write_through) begin
            Dataout <= Datain;
        end else if (do_read) begin
            Dataout <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_mem;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd;
    logic         wr;
    logic [W-1:0] din;
    logic [W-1:0] dout;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_dout;

    mem #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd      (rd),
        .wr      (wr),
        .Datain  (din),
        .Dataout (dout)
    );

    always #5 clk = ~clk;

    // Drive one edge worth of inputs, then advance the reference model.
    task automatic cycle(input logic r_s, input logic r, input logic w, input logic [W-1:0] d);
        bit read_ok;
        bit write_ok;
        rst = r_s;
        rd  = r;
        wr  = w;
        din = d;
        @(posedge clk);
        #1;
        if (r_s) begin
            q.delete();
            exp_dout = '0;
        end else if (r && w && q.size() == 0) begin
            exp_dout = d;
        end else begin
            read_ok  = r && (q.size() > 0);
            write_ok = w && ((q.size() < D) || read_ok);
            if (read_ok) exp_dout = q.pop_front();
            if (write_ok) q.push_back(d);
        end
        rst = 1'b0;
        rd  = 1'b0;
        wr  = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 8'h00);
        checks++;
        if (dout !== 8'h00) $display("FAIL reset_dout: got %h want %h", dout, 8'h00);
        else passed++;
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'h00) $display("FAIL reset_empty_read: got %h want %h", dout, 8'h00);
        else passed++;
        cycle(0, 1, 1, 8'h3C);
        checks++;
        if (dout !== 8'h3C) $display("FAIL reset_empty_wt: got %h want %h", dout, 8'h3C);
        else passed++;
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'h3C) $display("FAIL reset_wt_not_stored: got %h want %h", dout, 8'h3C);
        else passed++;
    endtask

    task automatic test_single();
        cycle(0, 0, 1, 8'hAA);
        checks++;
        if (dout !== 8'h3C) $display("FAIL single_hold_on_write: got %h want %h", dout, 8'h3C);
        else passed++;
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'hAA) $display("FAIL single_read: got %h want %h", dout, 8'hAA);
        else passed++;
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'hAA) $display("FAIL single_empty_again: got %h want %h", dout, 8'hAA);
        else passed++;
    endtask

    task automatic test_order();
        logic [W-1:0] want;
        for (int i = 1; i <= 3; i++) cycle(0, 0, 1, W'(i));
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 1, 0, 8'h00);
            want = W'(i);
            checks++;
            if (dout !== want) $display("FAIL order_read%0d: got %h want %h", i, dout, want);
            else passed++;
        end
    endtask

    task automatic test_full();
        logic [W-1:0] want;
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, W'(8'h10 + i));
        cycle(0, 0, 1, 8'hFF);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 8'h00);
            want = W'(8'h10 + i);
            checks++;
            if (dout !== want) $display("FAIL full_read%0d: got %h want %h", i, dout, want);
            else passed++;
        end
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'h1F) $display("FAIL full_overflow_dropped: got %h want %h", dout, 8'h1F);
        else passed++;
        // Simultaneous read and write while full keeps the FIFO full.
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, W'(8'h20 + i));
        cycle(0, 1, 1, 8'hEE);
        checks++;
        if (dout !== 8'h20) $display("FAIL full_rdwr_read: got %h want %h", dout, 8'h20);
        else passed++;
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 1, 0, 8'h00);
            want = (i == 16) ? 8'hEE : W'(8'h20 + i);
            checks++;
            if (dout !== want) $display("FAIL full_rdwr_drain%0d: got %h want %h", i, dout, want);
            else passed++;
        end
    endtask

    task automatic test_underflow_wt();
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'hEE) $display("FAIL underflow_hold: got %h want %h", dout, 8'hEE);
        else passed++;
        cycle(0, 1, 1, 8'h5C);
        checks++;
        if (dout !== 8'h5C) $display("FAIL wt_data: got %h want %h", dout, 8'h5C);
        else passed++;
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'h5C) $display("FAIL wt_count_zero: got %h want %h", dout, 8'h5C);
        else passed++;
        cycle(0, 0, 1, 8'h77);
        cycle(0, 0, 1, 8'h78);
        cycle(0, 1, 1, 8'h79);
        checks++;
        if (dout !== 8'h77) $display("FAIL mid_rdwr_oldest: got %h want %h", dout, 8'h77);
        else passed++;
        cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'h79) $display("FAIL mid_rdwr_stored: got %h want %h", dout, 8'h79);
        else passed++;
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 1, 8'h11);
        cycle(0, 0, 1, 8'h22);
        cycle(1, 1, 1, 8'h33);
        checks++;
        if (dout !== 8'h00) $display("FAIL rstmid_dout: got %h want %h", dout, 8'h00);
        else passed++;
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (dout !== 8'h00) $display("FAIL rstmid_empty_read: got %h want %h", dout, 8'h00);
        else passed++;
        cycle(0, 1, 1, 8'h99);
        checks++;
        if (dout !== 8'h99) $display("FAIL rstmid_empty_wt: got %h want %h", dout, 8'h99);
        else passed++;
    endtask

    task automatic test_random();
        bit r;
        bit w;
        bit rs;
        int wr_pct;
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            wr_pct = ((i / 60) % 2 == 0) ? 80 : 25;
            w  = ($urandom_range(99) < wr_pct);
            r  = ($urandom_range(99) < (100 - wr_pct));
            rs = ($urandom_range(199) == 0);
            cycle(rs, r, w, W'($urandom));
            checks++;
            if (dout !== exp_dout) $display("FAIL random_cycle%0d: got %h want %h", i, dout, exp_dout);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        rd  = 1'b0;
        wr  = 1'b0;
        din = '0;
        exp_dout = '0;
        test_reset();
        test_single();
        test_order();
        test_full();
        test_underflow_wt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
